// File: rtl/apb_pkg.sv
// Shared APB widths, requester state encoding and address helpers.
// Completer-side blocks and the requester both import this so the widths never drift.
package apb_pkg;

  localparam int ADDR_WIDTH      = 16;
  localparam int DATA_WIDTH      = 32;
  localparam int STRB_WIDTH      = 4;
  localparam int DEFAULT_TIMEOUT = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } state;

  // Word-aligned accesses only; the completer has no byte-lane steering.
  function automatic logic validAlign(input logic [ADDR_WIDTH-1:0] addr);
    return (addr & ADDR_WIDTH'(3)) == '0;
  endfunction

  // Upper half of the map is the privileged, non-secure, instruction window.
  function automatic logic [2:0] getPprot(input logic [ADDR_WIDTH-1:0] addr);
    return ((addr >> (ADDR_WIDTH - 1)) != '0) ? 3'b111 : 3'b000;
  endfunction

endpackage

// File: rtl/apb_requester.sv
// APB requester: one valid/ready request at a time -> SETUP/ACCESS, one-cycle response pulse.
// Latency 3 cycles accept->rsp with zero waits (1 if misaligned); req_ready low whenever busy.
module apb_requester
  import apb_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT
) (
  input  logic                  PCLK,
  input  logic                  PRESETn,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  input  logic [STRB_WIDTH-1:0] req_strb,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic [ADDR_WIDTH-1:0] PADDR,
  output logic [2:0]            PPROT,
  output logic                  PSEL,
  output logic                  PENABLE,
  output logic                  PWRITE,
  output logic [DATA_WIDTH-1:0] PWDATA,
  output logic [STRB_WIDTH-1:0] PSTRB,
  input  logic                  PREADY,
  input  logic [DATA_WIDTH-1:0] PRDATA,
  input  logic                  PSLVERR
);

  localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CW-1:0] CNT_MAX   = '1;
  localparam logic [CW-1:0] CNT_LIMIT = CW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  state            r_state;
  state            w_state_nxt;
  logic [CW-1:0]   r_cnt;
  logic            w_accept;
  logic            w_timeout;

  always_comb begin
    w_accept    = req_valid && req_ready;
    w_timeout   = (TIMEOUT_CYCLES != 0) && (r_cnt == CNT_LIMIT);
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_state_nxt = validAlign(req_addr) ? SETUP : ERROR;
      SETUP:   w_state_nxt = ACCESS;
      ACCESS:  if (PREADY || w_timeout) w_state_nxt = IDLE;
      ERROR:   w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      req_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      PADDR     <= '0;
      PPROT     <= '0;
      PSEL      <= 1'b0;
      PENABLE   <= 1'b0;
      PWRITE    <= 1'b0;
      PWDATA    <= '0;
      PSTRB     <= '0;
    end else begin
      r_state   <= w_state_nxt;
      req_ready <= (w_state_nxt == IDLE);
      rsp_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            if (validAlign(req_addr)) begin
              PADDR  <= req_addr;
              PWRITE <= req_write;
              PWDATA <= req_wdata;
              PSTRB  <= req_write ? req_strb : '0;
              PPROT  <= getPprot(req_addr);
              PSEL   <= 1'b1;
            end else begin
              // Misaligned: answer locally, the bus never sees it.
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
            end
          end
        end
        SETUP: begin
          PENABLE <= 1'b1;
          r_cnt   <= '0;
        end
        ACCESS: begin
          if (PREADY) begin
            if (!PWRITE) rsp_rdata <= PRDATA;
            rsp_err   <= PSLVERR;
            rsp_valid <= 1'b1;
            PSEL      <= 1'b0;
            PENABLE   <= 1'b0;
          end else begin
            if (w_timeout) begin
              rsp_err   <= 1'b1;
              rsp_valid <= 1'b1;
              PSEL      <= 1'b0;
              PENABLE   <= 1'b0;
            end
            if (r_cnt != CNT_MAX) r_cnt <= r_cnt + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_requester.sv
// Directed bench for apb_requester: per-cycle compare against a timeline model plus literal checks.
module tb_apb_requester;
  import apb_pkg::*;

  localparam int TO = 16;

  logic        PCLK = 1'b0;
  logic        PRESETn = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [15:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic [3:0]  req_strb = '0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [15:0] PADDR;
  logic [2:0]  PPROT;
  logic        PSEL;
  logic        PENABLE;
  logic        PWRITE;
  logic [31:0] PWDATA;
  logic [3:0]  PSTRB;
  logic        PREADY = 1'b0;
  logic [31:0] PRDATA = '0;
  logic        PSLVERR = 1'b0;

  apb_requester #(.TIMEOUT_CYCLES(TO)) dut (
    .PCLK(PCLK), .PRESETn(PRESETn),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_strb(req_strb),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .PADDR(PADDR), .PPROT(PPROT), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PWDATA(PWDATA), .PSTRB(PSTRB), .PREADY(PREADY), .PRDATA(PRDATA), .PSLVERR(PSLVERR)
  );

  always #5 PCLK = ~PCLK;

  int cyc = 0;
  always @(posedge PCLK) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Transaction timeline model: cycle offsets relative to the accept edge.
  bit          chk_en = 1'b0;
  int          acc = -1000;
  int          m_L = 0;
  int          m_R = 0;
  bit          m_aligned = 1'b1;
  bit          m_err = 1'b0;
  logic [15:0] m_paddr = '0;
  logic        m_pwrite = 1'b0;
  logic [31:0] m_pwdata = '0;
  logic [3:0]  m_pstrb = '0;
  logic [2:0]  m_pprot = '0;
  logic [31:0] m_rdata = '0;

  int cmp_off;
  bit e_psel, e_pen, e_rv, e_rdy;

  always @(negedge PCLK) begin
    #1;
    if (chk_en) begin
      cmp_off = cyc - acc + 1;
      e_psel  = m_aligned && cmp_off >= 1 && cmp_off <= m_L;
      e_pen   = m_aligned && cmp_off >= 2 && cmp_off <= m_L;
      e_rv    = (cmp_off == m_R);
      e_rdy   = !(cmp_off >= 1 && cmp_off <= (m_aligned ? m_L : 1));
      chk("psel", PSEL, e_psel);
      chk("penable", PENABLE, e_pen);
      chk("rsp_valid", rsp_valid, e_rv);
      chk("req_ready", req_ready, e_rdy);
      chk("paddr", PADDR, m_paddr);
      chk("pwrite", PWRITE, m_pwrite);
      chk("pwdata", PWDATA, m_pwdata);
      chk("pstrb", PSTRB, m_pstrb);
      chk("pprot", PPROT, m_pprot);
      if (e_rv) begin
        chk("rsp_err", rsp_err, m_err);
        chk("rsp_rdata", rsp_rdata, m_rdata);
      end
    end
  end

  // Observations gathered by the driver for the literal checks.
  int          o_psel, o_pen, o_rsp_off;
  logic        o_err, o_rdy;
  logic [31:0] o_rdata;
  logic [2:0]  o_pprot;
  logic [3:0]  o_pstrb;

  task automatic run_txn(input bit wr, input logic [15:0] addr, input logic [31:0] wd,
                         input logic [3:0] st, input int nwait, input logic [31:0] rd,
                         input bit slverr);
    bit al, to;
    int L, R, w;
    al = (addr[1:0] == 2'b00);
    to = (TO != 0) && (nwait >= TO);
    L  = to ? TO + 1 : nwait + 2;
    R  = al ? L + 1 : 1;
    @(negedge PCLK);
    w = 0;
    while (!req_ready && w < 40) begin
      @(negedge PCLK);
      w++;
    end
    if (!req_ready) chk("req_ready_wait", req_ready, 1);
    req_valid = 1'b1; req_write = wr; req_addr = addr; req_wdata = wd; req_strb = st;
    acc = cyc + 1; m_L = L; m_R = R; m_aligned = al; m_err = !al || to || slverr;
    o_psel = 0; o_pen = 0; o_rsp_off = -1; o_err = 1'bx; o_rdy = 1'bx; o_rdata = 'x;
    for (int off = 1; off <= R + 1; off++) begin
      @(negedge PCLK);
      if (off == 1) begin
        req_valid = 1'b0;
        o_pprot = PPROT;
        o_pstrb = PSTRB;
        if (al) begin
          m_paddr = addr; m_pwrite = wr; m_pwdata = wd;
          m_pstrb = wr ? st : 4'h0;
          m_pprot = addr[15] ? 3'b111 : 3'b000;
        end
      end
      if (off == R && al && !to && !wr) m_rdata = rd;
      if (PSEL) o_psel++;
      if (PENABLE) o_pen++;
      if (rsp_valid && o_rsp_off < 0) begin
        o_rsp_off = off; o_err = rsp_err; o_rdata = rsp_rdata; o_rdy = req_ready;
      end
      PREADY  = (off - 2 == nwait);
      PRDATA  = PREADY ? rd : ~rd;
      PSLVERR = PREADY ? slverr : 1'b1;
    end
    PREADY = 1'b0; PSLVERR = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #2 PRESETn = 1'b0;
    #2;
    chk("rst_psel", PSEL, 0);
    chk("rst_penable", PENABLE, 0);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_paddr", PADDR, 0);
    chk("rst_pwdata", PWDATA, 0);
    repeat (3) @(negedge PCLK);
    PRESETn = 1'b1;
    #1 chk("rdy_before_edge", req_ready, 0);
    @(negedge PCLK);
    chk("rdy_after_edge", req_ready, 1);
    chk_en = 1'b1;

    run_txn(1, 16'h0010, 32'hDEADBEEF, 4'hF, 0, 32'h0BAD0BAD, 0);
    chk("t1_psel_cycles", o_psel, 2);
    chk("t1_penable_cycles", o_pen, 1);
    chk("t1_pprot", o_pprot, 3'b000);
    chk("t1_rsp_off", o_rsp_off, 3);
    chk("t1_err", o_err, 0);

    run_txn(0, 16'h0020, 32'h55555555, 4'hA, 3, 32'h12345678, 0);
    chk("t2_rsp_off", o_rsp_off, 6);
    chk("t2_rdata", o_rdata, 32'h12345678);
    chk("t2_pstrb", o_pstrb, 4'h0);
    chk("t2_penable_cycles", o_pen, 4);

    run_txn(0, 16'h0002, 32'h0, 4'h0, 0, 32'h99999999, 0);
    chk("t3_psel_cycles", o_psel, 0);
    chk("t3_rsp_off", o_rsp_off, 1);
    chk("t3_err", o_err, 1);

    run_txn(1, 16'h8004, 32'hCAFEF00D, 4'h3, 1, 32'h0, 1);
    chk("t4_pprot", o_pprot, 3'b111);
    chk("t4_pstrb", o_pstrb, 4'h3);
    chk("t4_err", o_err, 1);
    chk("t4_rsp_off", o_rsp_off, 4);

    run_txn(0, 16'h0030, 32'h0, 4'h0, 40, 32'hBADBAD00, 0);
    chk("t5_penable_cycles", o_pen, 16);
    chk("t5_rsp_off", o_rsp_off, 18);
    chk("t5_err", o_err, 1);
    chk("t5_rdata_held", o_rdata, 32'h12345678);
    chk("t5_rdy_back", o_rdy, 1);

    run_txn(0, 16'h0034, 32'h0, 4'h0, 15, 32'h0F0F0F0F, 0);
    chk("t6_rsp_off", o_rsp_off, 18);
    chk("t6_err", o_err, 0);
    chk("t6_rdata", o_rdata, 32'h0F0F0F0F);

    run_txn(0, 16'h8008, 32'h0, 4'h0, 0, 32'hA5A5A5A5, 1);
    chk("t7_err", o_err, 1);
    chk("t7_rdata", o_rdata, 32'hA5A5A5A5);

    // Reset in the middle of an ACCESS phase.
    chk_en = 1'b0;
    @(negedge PCLK);
    req_valid = 1'b1; req_write = 1'b1; req_addr = 16'h0050; req_wdata = 32'h77777777; req_strb = 4'hF;
    @(negedge PCLK);
    req_valid = 1'b0;
    repeat (2) @(negedge PCLK);
    chk("pre_rst_penable", PENABLE, 1);
    chk("pre_rst_paddr", PADDR, 16'h0050);
    #2 PRESETn = 1'b0;
    #1;
    chk("mid_rst_psel", PSEL, 0);
    chk("mid_rst_penable", PENABLE, 0);
    chk("mid_rst_paddr", PADDR, 0);
    chk("mid_rst_pwrite", PWRITE, 0);
    chk("mid_rst_pwdata", PWDATA, 0);
    chk("mid_rst_pstrb", PSTRB, 0);
    chk("mid_rst_rdata", rsp_rdata, 0);
    chk("mid_rst_req_ready", req_ready, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge PCLK);
      chk("mid_rst_rsp_valid", rsp_valid, 0);
    end
    PRESETn = 1'b1;
    m_paddr = '0; m_pwrite = 1'b0; m_pwdata = '0; m_pstrb = '0; m_pprot = '0; m_rdata = '0;
    acc = -1000;
    @(negedge PCLK);
    chk("post_rst_rdy", req_ready, 1);
    chk("post_rst_rsp_valid", rsp_valid, 0);
    chk_en = 1'b1;

    run_txn(1, 16'h0040, 32'h11223344, 4'hF, 0, 32'h0, 0);
    chk("t8_psel_cycles", o_psel, 2);
    chk("t8_rsp_off", o_rsp_off, 3);
    chk("t8_err", o_err, 0);
    chk("t8_rdata_zero", o_rdata, 32'h0);

    repeat (2) @(negedge PCLK);
    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
